// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit that sits beside the ALU in EX. Runs
//   MULT/MULTU/DIV/DIVU one radix-2 step per cycle into the architectural
//   HI/LO pair, and services MTHI/MTLO writes in a single cycle.
//
// Ports
//   Clk     in   1      clock, rising edge
//   Reset   in   1      asynchronous, active-high, clears all state
//   Start   in   1      op valid, only looked at while idle
//   MDCtrl  in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                       100 MTHI, 101 MTLO, 11x no-op
//   BusA    in   WIDTH  rs: multiplicand, dividend, or MTHI/MTLO data
//   BusB    in   WIDTH  rt: multiplier or divisor
//   Flush   in   1      cancel the in-flight op
//   HiOut   out  WIDTH  HI register
//   LoOut   out  WIDTH  LO register
//   Busy    out  1      mult/div in progress (registered)
//   Done    out  1      one-cycle pulse after HI/LO were written by mult/div
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for Start; MTHI/MTLO handled here
//   S_RUN  | one shift-add / shift-subtract step per cycle, WIDTH steps
//   S_FIX  | sign correction and HI/LO write
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MDCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic             Flush,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, next_state;

  // control strobes from the output process
  logic accept;
  logic mt_hi;
  logic mt_lo;
  logic do_step;
  logic do_write;

  // datapath registers
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_op;   // |A| for multiply (addend), |B| for divide (divisor)
  logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // operand magnitudes at issue
  logic             signed_op;
  logic             a_is_neg;
  logic             b_is_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // step results
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  // FIX results
  logic               neg_q;
  logic               b_zero;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (!Flush && Start && !MDCtrl[2]) next_state = S_RUN;
      S_RUN: begin
        if (Flush)                 next_state = S_IDLE;
        else if (cnt == CW'(1))    next_state = S_FIX;
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (control strobes). Flush blocks everything, including a
  // Start that arrives while idle.
  // -------------------------------------------------------------------------
  always_comb begin
    accept   = 1'b0;
    mt_hi    = 1'b0;
    mt_lo    = 1'b0;
    do_step  = 1'b0;
    do_write = 1'b0;
    case (state)
      S_IDLE: begin
        accept = !Flush && Start && !MDCtrl[2];
        mt_hi  = !Flush && Start && (MDCtrl == OP_MTHI);
        mt_lo  = !Flush && Start && (MDCtrl == OP_MTLO);
      end
      S_RUN:   do_step  = !Flush;
      S_FIX:   do_write = !Flush;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand magnitudes. MDCtrl[0]=0 selects the signed form of both ops.
  // The most-negative value maps onto its own bit pattern, which is the
  // correct unsigned magnitude.
  // -------------------------------------------------------------------------
  always_comb begin
    signed_op = ~MDCtrl[0];
    a_is_neg  = signed_op & BusA[WIDTH-1];
    b_is_neg  = signed_op & BusB[WIDTH-1];
    abs_a     = a_is_neg ? -BusA : BusA;
    abs_b     = b_is_neg ? -BusB : BusB;
  end

  // -------------------------------------------------------------------------
  // One radix-2 step.
  //   Multiply: add the multiplicand into the upper half when the current
  //   multiplier LSB is set, then shift the whole accumulator right.
  //   Divide (restoring): shift the remainder left pulling in the next
  //   dividend bit, try subtracting the divisor, keep it if no borrow.
  //   The remainder is always below the divisor, so the W+1-bit difference
  //   has its top bit set exactly when the subtraction borrows.
  // -------------------------------------------------------------------------
  always_comb begin
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_op} : '0);
    mul_next    = {mul_sum, acc[WIDTH-1:1]};

    div_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff    = div_shifted - {1'b0, mag_op};
    div_rem     = div_diff[WIDTH] ? div_shifted[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_next    = {div_rem, acc[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  // -------------------------------------------------------------------------
  // Sign correction. A zero divisor leaves the quotient at all ones and the
  // remainder at |A|; restoring the sign of A then gives HI=A for both DIV
  // and DIVU. The quotient of a zero divisor must not be negated.
  // -------------------------------------------------------------------------
  always_comb begin
    neg_q  = a_neg ^ b_neg;
    b_zero = (mag_op == '0);
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      lo_fix = (neg_q && !b_zero) ? -quo : quo;
      hi_fix = a_neg ? -rem : rem;
    end else begin
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      mag_op <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (next_state != S_IDLE);
      done_q <= do_write;

      if (accept) begin
        is_div <= MDCtrl[1];
        a_neg  <= a_is_neg;
        b_neg  <= b_is_neg;
        mag_op <= MDCtrl[1] ? abs_b : abs_a;
        acc    <= {{WIDTH{1'b0}}, (MDCtrl[1] ? abs_a : abs_b)};
        cnt    <= CW'(WIDTH);
      end else if (do_step) begin
        acc <= is_div ? div_next : mul_next;
        cnt <= cnt - CW'(1);
      end

      if (do_write) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
      if (mt_hi) hi_q <= BusA;
      if (mt_lo) lo_q <= BusA;
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (WIDTH=32): directed cases with literal
// results, then randomized traffic, all compared every cycle against an
// arithmetic model of HI/LO/Busy/Done.
module tb_mult_div_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDCtrl;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic        Flush;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int passes = 0;

  // model state
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done;
  int          m_left;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .MDCtrl (MDCtrl),
    .BusA   (BusA),
    .BusB   (BusB),
    .Flush  (Flush),
    .HiOut  (HiOut),
    .LoOut  (LoOut),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic for one mult/div op.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    int sa, sb;
    hi = '0; lo = '0;
    case (op)
      3'b000: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        {hi, lo} = p;
      end
      3'b001: begin
        p = {32'b0, a} * {32'b0, b};
        {hi, lo} = p;
      end
      3'b010: begin
        sa = a; sb = b;
        if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = 32'h80000000; hi = 32'd0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // Behavioural model: an accepted op produces its result WIDTH+1 edges later.
  initial begin
    m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_left = 0; p_hi = 0; p_lo = 0;
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_left = 0;
      end else if (m_busy) begin
        m_done = 0;
        if (Flush) m_busy = 0;
        else if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_busy = 0; m_done = 1;
        end else m_left--;
      end else begin
        m_done = 0;
        if (!Flush && Start) begin
          case (MDCtrl)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              model_op(MDCtrl, BusA, BusB, p_hi, p_lo);
              m_busy = 1; m_left = 32;
            end
            3'b100: m_hi = BusA;
            3'b101: m_lo = BusA;
            default: ;
          endcase
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      chk("cyc_hi",   {32'b0, HiOut}, {32'b0, m_hi});
      chk("cyc_lo",   {32'b0, LoOut}, {32'b0, m_lo});
      chk("cyc_busy", {63'b0, Busy},  {63'b0, m_busy});
      chk("cyc_done", {63'b0, Done},  {63'b0, m_done});
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 100) begin @(posedge Clk); #1; n++; end
    if (Busy) chk("idle_timeout", {63'b0, Busy}, 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int edges, busy_cnt;
    wait_idle();
    @(negedge Clk);
    Start = 1; MDCtrl = op; BusA = a; BusB = b;
    @(posedge Clk); #1;
    Start = 0;
    edges = 0; busy_cnt = 0;
    while (!Done && edges < 100) begin
      if (Busy) busy_cnt++;
      @(posedge Clk); #1;
      edges++;
    end
    chk({name, "_hi"},   {32'b0, HiOut}, {32'b0, ehi});
    chk({name, "_lo"},   {32'b0, LoOut}, {32'b0, elo});
    chk({name, "_lat"},  64'(edges),     64'd33);
    chk({name, "_busy"}, 64'(busy_cnt),  64'd33);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    logic [31:0] h, l, sv_hi, sv_lo;
    int n, done_seen;

    Start = 0; MDCtrl = 0; BusA = 0; BusB = 0; Flush = 0;
    Reset = 1;
    @(posedge Clk); #1;
    chk("rst_hi",   {32'b0, HiOut}, 64'd0);
    chk("rst_lo",   {32'b0, LoOut}, 64'd0);
    chk("rst_busy", {63'b0, Busy},  64'd0);
    chk("rst_done", {63'b0, Done},  64'd0);
    @(negedge Clk); Reset = 0;

    // pin the model itself
    model_op(3'b010, 32'hFFFFFFF9, 32'd2, h, l);
    chk("model_div_neg", {h, l}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    model_op(3'b000, 32'hFFFFFFFF, 32'd2, h, l);
    chk("model_mult",    {h, l}, {32'hFFFFFFFF, 32'hFFFFFFFE});
    model_op(3'b010, 32'h80000000, 32'hFFFFFFFF, h, l);
    chk("model_div_ovf", {h, l}, {32'h00000000, 32'h80000000});

    run_op("mult_m1x2",   3'b000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu_m1x2",  3'b001, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
    run_op("multu_max",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_m7_2",    3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2",    3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100_7",  3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_op("divu_5_0",    3'b011, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
    run_op("div_m7_0",    3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",     3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI, then MTLO attempted while a MULT is busy
    @(negedge Clk); Start = 1; MDCtrl = 3'b100; BusA = 32'h00001234;
    @(posedge Clk); #1; Start = 0;
    chk("mthi", {32'b0, HiOut}, 64'h00001234);
    sv_lo = LoOut;
    @(negedge Clk); Start = 1; MDCtrl = 3'b000; BusA = 32'd3; BusB = 32'd4;
    @(posedge Clk); #1; Start = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); Start = 1; MDCtrl = 3'b101; BusA = 32'h00005555;
    @(posedge Clk); #1; Start = 0;
    chk("mtlo_busy_ignored", {32'b0, LoOut}, {32'b0, sv_lo});
    chk("mthi_held_in_run",  {32'b0, HiOut}, 64'h00001234);
    n = 0;
    while (!Done && n < 100) begin @(posedge Clk); #1; n++; end
    chk("mult_3x4", {HiOut, LoOut}, 64'h0000000C);

    // Flush at cycle 10 of a DIV
    wait_idle();
    sv_hi = HiOut; sv_lo = LoOut;
    @(negedge Clk); Start = 1; MDCtrl = 3'b010; BusA = 32'd1000; BusB = 32'd3;
    @(posedge Clk); #1; Start = 0;
    repeat (9) @(posedge Clk);
    @(negedge Clk); Flush = 1;
    @(posedge Clk); #1; Flush = 0;
    chk("flush_busy", {63'b0, Busy}, 64'd0);
    chk("flush_hilo", {HiOut, LoOut}, {sv_hi, sv_lo});
    done_seen = 0;
    repeat (40) begin @(posedge Clk); #1; if (Done) done_seen++; end
    chk("flush_no_done", 64'(done_seen), 64'd0);

    // Async reset in the middle of a MULT
    @(negedge Clk); Start = 1; MDCtrl = 3'b001; BusA = 32'hDEADBEEF; BusB = 32'd9;
    @(posedge Clk); #1; Start = 0;
    chk("pre_rst_hilo_nonzero", 64'({HiOut, LoOut} != 64'd0), 64'd1);
    repeat (4) @(posedge Clk);
    #3 Reset = 1;
    #1;
    chk("arst_hi",   {32'b0, HiOut}, 64'd0);
    chk("arst_lo",   {32'b0, LoOut}, 64'd0);
    chk("arst_busy", {63'b0, Busy},  64'd0);
    chk("arst_done", {63'b0, Done},  64'd0);
    @(negedge Clk); Reset = 0;

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      @(negedge Clk);
      Start  = ($urandom_range(0, 3) == 0);
      MDCtrl = 3'($urandom_range(0, 7));
      BusA   = rnd_val();
      BusB   = rnd_val();
      Flush  = ($urandom_range(0, 99) == 0);
      Reset  = (i == 2500);
    end
    @(negedge Clk);
    Start = 0; Flush = 0; Reset = 0;
    repeat (40) @(posedge Clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
